// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared constants for the UART command parser: ASCII codes of the
//   command alphabet, FSM state encodings, error codes and the bit
//   positions of the one-hot pulse vector inside cmd_parser.
//   No ports (package).
package uart_cmd_pkg;

  // ASCII control and separator characters
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  // Command letters
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_c     = 8'h63;
  localparam logic [7:0] ASCII_d     = 8'h64;
  localparam logic [7:0] ASCII_m     = 8'h6D;
  localparam logic [7:0] ASCII_r     = 8'h72;
  localparam logic [7:0] ASCII_s     = 8'h73;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARG      = 2'd1;
  localparam logic [1:0] ST_WAIT_CR  = 2'd2;

  // Error codes reported on o_err_code
  localparam logic [1:0] ERR_UNKNOWN = 2'd0;
  localparam logic [1:0] ERR_DIGIT   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Bit positions in the registered pulse vector
  localparam int P_RUN      = 9;
  localparam int P_STOP     = 8;
  localparam int P_CLEAR    = 7;
  localparam int P_MODE     = 6;
  localparam int P_DISP     = 5;
  localparam int P_SEC      = 4;
  localparam int P_MIN      = 3;
  localparam int P_HOUR     = 2;
  localparam int P_SET_TIME = 1;
  localparam int P_ERR      = 0;
  localparam int NUM_PULSES = 10;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// cmd_parser_if
//   Bundles the RX FIFO handshake and the command outputs of cmd_parser.
//   master : byte source / command consumer side (drives rx_data, rx_not_empty)
//   slave  : parser side (drives rx_pop and all command outputs)
interface cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_not_empty;
  logic       rx_pop;
  logic       run;
  logic       stop;
  logic       clear;
  logic       mode;
  logic       display_mode;
  logic       sec_plus;
  logic       min_plus;
  logic       hour_plus;
  logic       set_time;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output rx_data, rx_not_empty,
    input  rx_pop, run, stop, clear, mode, display_mode, sec_plus, min_plus,
           hour_plus, set_time, set_hour, set_min, set_sec, err, err_code
  );

  modport slave (
    input  rx_data, rx_not_empty,
    output rx_pop, run, stop, clear, mode, display_mode, sec_plus, min_plus,
           hour_plus, set_time, set_hour, set_min, set_sec, err, err_code
  );
endinterface

// File: rtl/cmd_parser_timeout.sv
// cmd_timeout
//   Inter-byte idle counter for multi-byte commands.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : count enable (parser is inside a command)
//   i_clr          : restart the idle count (a byte was popped)
//   o_expired      : the current cycle is idle cycle number TIMEOUT_CYCLES
module cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  // cnt_q holds the number of idle cycles already completed, so the
  // TIMEOUT_CYCLES-th idle cycle is the one that sees LAST.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en || i_clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_en && (cnt_q == LAST);

endmodule

// File: rtl/cmd_parser.sv
// cmd_parser
//   Decodes ASCII commands from an FWFT RX FIFO into one-cycle pulses.
//   Single-letter commands pulse immediately; "T" + six digits HHMMSS +
//   CR/LF loads a time value. Errors pulse o_err with a code.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_rx_data, i_rx_not_empty, o_rx_pop : FIFO head byte and pop strobe
//   o_run .. o_hour_plus    : command pulses
//   o_set_time, o_set_hour/min/sec : time load pulse and held values
//   o_err, o_err_code       : error pulse and its code
module cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 27
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_not_empty,
  output logic       o_rx_pop,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_display_mode,
  output logic       o_sec_plus,
  output logic       o_min_plus,
  output logic       o_hour_plus,
  output logic       o_set_time,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  logic [1:0]            state_d, state_q;
  logic [2:0]            idx_d, idx_q;
  logic [5:0][3:0]       dig_d, dig_q;
  logic [NUM_PULSES-1:0] pulse_d, pulse_q;
  logic [1:0]            err_code_d, err_code_q;
  logic [4:0]            hour_d, hour_q;
  logic [5:0]            min_d, min_q;
  logic [5:0]            sec_d, sec_q;
  logic [6:0]            hour_bin, min_bin, sec_bin;
  logic                  tmo_en, tmo_expired;

  // Popping is unconditional on data presence; reset gates it so no byte
  // is lost while the parser cannot interpret it.
  assign o_rx_pop = i_rx_not_empty && i_rst_n;

  assign tmo_en = (state_q != ST_IDLE);

  cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (tmo_en),
    .i_clr    (i_rx_not_empty),
    .o_expired(tmo_expired)
  );

  // Digits are stored in arrival order: HH MM SS
  assign hour_bin = bcd2bin(dig_q[0], dig_q[1]);
  assign min_bin  = bcd2bin(dig_q[2], dig_q[3]);
  assign sec_bin  = bcd2bin(dig_q[4], dig_q[5]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dig_d      = dig_q;
    pulse_d    = '0;
    err_code_d = err_code_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;

    // A popped byte always takes priority over a coincident timeout.
    if (i_rx_not_empty) begin
      case (state_q)
        ST_IDLE: begin
          case (i_rx_data)
            ASCII_r: pulse_d[P_RUN]   = 1'b1;
            ASCII_s: pulse_d[P_STOP]  = 1'b1;
            ASCII_c: pulse_d[P_CLEAR] = 1'b1;
            ASCII_m: pulse_d[P_MODE]  = 1'b1;
            ASCII_d: pulse_d[P_DISP]  = 1'b1;
            ASCII_S: pulse_d[P_SEC]   = 1'b1;
            ASCII_M: pulse_d[P_MIN]   = 1'b1;
            ASCII_H: pulse_d[P_HOUR]  = 1'b1;
            ASCII_T: begin
              state_d = ST_ARG;
              idx_d   = '0;
            end
            ASCII_CR, ASCII_LF, ASCII_SPACE, ASCII_ESC: ;
            default: begin
              pulse_d[P_ERR] = 1'b1;
              err_code_d     = ERR_UNKNOWN;
            end
          endcase
        end
        ST_ARG: begin
          if (is_digit(i_rx_data)) begin
            dig_d[idx_q] = i_rx_data[3:0];
            if (idx_q == 3'd5) begin
              state_d = ST_WAIT_CR;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else if (i_rx_data == ASCII_ESC) begin
            state_d = ST_IDLE;
          end else begin
            pulse_d[P_ERR] = 1'b1;
            err_code_d     = ERR_DIGIT;
            state_d        = ST_IDLE;
          end
        end
        ST_WAIT_CR: begin
          if ((i_rx_data == ASCII_CR) || (i_rx_data == ASCII_LF)) begin
            if ((hour_bin < 7'd24) && (min_bin < 7'd60) && (sec_bin < 7'd60)) begin
              pulse_d[P_SET_TIME] = 1'b1;
              hour_d              = hour_bin[4:0];
              min_d               = min_bin[5:0];
              sec_d               = sec_bin[5:0];
            end else begin
              pulse_d[P_ERR] = 1'b1;
              err_code_d     = ERR_RANGE;
            end
            state_d = ST_IDLE;
          end else if (i_rx_data == ASCII_ESC) begin
            state_d = ST_IDLE;
          end else begin
            pulse_d[P_ERR] = 1'b1;
            err_code_d     = ERR_DIGIT;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expired) begin
      pulse_d[P_ERR] = 1'b1;
      err_code_d     = ERR_TIMEOUT;
      state_d        = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      dig_q      <= '0;
      pulse_q    <= '0;
      err_code_q <= ERR_UNKNOWN;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dig_q      <= dig_d;
      pulse_q    <= pulse_d;
      err_code_q <= err_code_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
    end
  end

  assign o_run          = pulse_q[P_RUN];
  assign o_stop         = pulse_q[P_STOP];
  assign o_clear        = pulse_q[P_CLEAR];
  assign o_mode         = pulse_q[P_MODE];
  assign o_display_mode = pulse_q[P_DISP];
  assign o_sec_plus     = pulse_q[P_SEC];
  assign o_min_plus     = pulse_q[P_MIN];
  assign o_hour_plus    = pulse_q[P_HOUR];
  assign o_set_time     = pulse_q[P_SET_TIME];
  assign o_err          = pulse_q[P_ERR];
  assign o_err_code     = err_code_q;
  assign o_set_hour     = hour_q;
  assign o_set_min      = min_q;
  assign o_set_sec      = sec_q;

endmodule
